pe_row_acc: RTL

Parametrised successor of the 16-PE mode row. It holds NUM_PE stationary-weight multiply lanes and a systolic pixel shift output. A contiguous window of cast lanes selects its pixel source by mode. Each lane adds a per-lane accumulator over a programmable number of beats and returns a valid/ready partial-sum handshake towards the DLA accumulation buffer.

---
 rtl/pe_row_acc.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pe_row_acc.sv
// -----------------------------------------------------------------------------
// pe_row_acc
//
// One row of NUM_PE stationary-weight multiply lanes with per-lane group
// accumulators. Each accepted beat selects one pixel per lane, passes the
// selected pixels on to the next row, multiplies them by the stored weights
// and adds the products into saturating accumulators. After acc_len beats the
// group sums are presented as a psum vector under a valid/ready handshake.
//
// Pipeline: S1 pixel select/register -> S2 multiply -> S3 accumulate/output.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (clears every register)
//   clear        synchronous flush of pipeline, counter and accumulators
//   mode         cast-lane pixel source (direct / cast / broadcast / gated)
//   acc_len      beats per accumulation group, latched per group (0 acts as 1)
//   in_valid     input beat valid
//   in_ready     input beat accepted when in_valid & in_ready
//   pixel        per-lane pixels (signed DATA_W)
//   pixel_cast   cast pixels for the CAST_NUM lanes starting at CAST_BASE
//   weight_load  capture weight into the weight registers
//   weight       per-lane weights (signed DATA_W)
//   next_pixel   registered selected pixels towards the next row
//   out_valid    psum valid
//   out_ready    psum consumed when out_valid & out_ready
//   psum         per-lane group sums (signed ACC_W, saturated)
//   sat          at least one lane clamped during the reported group
// -----------------------------------------------------------------------------
module pe_row_acc #(
    parameter int NUM_PE    = 16,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int CAST_BASE = 9,
    parameter int CAST_NUM  = 3,
    parameter int LEN_W     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic [1:0]                       mode,
    input  logic [LEN_W-1:0]                 acc_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_PE-1:0][DATA_W-1:0]    pixel,
    input  logic [CAST_NUM-1:0][DATA_W-1:0]  pixel_cast,
    input  logic                             weight_load,
    input  logic [NUM_PE-1:0][DATA_W-1:0]    weight,
    output logic [NUM_PE-1:0][DATA_W-1:0]    next_pixel,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_PE-1:0][ACC_W-1:0]     psum,
    output logic                             sat
);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_CAST   = 2'd1,
        MODE_BCAST  = 2'd2,
        MODE_GATE   = 2'd3
    } mode_e;

    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Stage state
    logic [NUM_PE-1:0][DATA_W-1:0] wreg;
    logic                          v1, last1;
    logic                          v2, last2;
    logic signed [PROD_W-1:0]      prod [NUM_PE];
    logic signed [ACC_W-1:0]       acc  [NUM_PE];
    logic                          sticky;

    // Group counter state
    logic [LEN_W-1:0]              count;
    logic [LEN_W-1:0]              len_q;

    // Combinational helpers
    logic                          en;
    logic                          accept;
    logic [LEN_W-1:0]              eff_len;
    logic [LEN_W-1:0]              last_idx;
    logic                          last_beat;
    logic [NUM_PE-1:0][DATA_W-1:0] sel_pix;
    logic signed [ACC_W:0]         sum     [NUM_PE];
    logic signed [ACC_W-1:0]       acc_new [NUM_PE];
    logic                          any_clamp;

    // A held psum that nobody takes freezes the whole row, and the stall is
    // visible upstream in the same cycle.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;

    // The first beat of a group uses the live acc_len; later beats use the
    // copy latched on that first beat, so mid-group changes wait a group.
    assign eff_len   = (count == '0) ? acc_len : len_q;
    assign last_idx  = (eff_len == '0) ? '0 : eff_len - LEN_W'(1);
    assign last_beat = (count == last_idx);

    // Lane pixel select: only the cast window looks at mode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_pix = pixel;
        for (int j = 0; j < CAST_NUM; j++) begin
            case (mode_e'(mode))
                MODE_DIRECT: sel_pix[CAST_BASE+j] = pixel[CAST_BASE+j];
                MODE_CAST:   sel_pix[CAST_BASE+j] = pixel_cast[j];
                MODE_BCAST:  sel_pix[CAST_BASE+j] = pixel_cast[0];
                default:     sel_pix[CAST_BASE+j] = '0;
            endcase
        end
    end

    // Saturating accumulate. One guard bit is enough because the sign-extended
    // product never exceeds the accumulator range.
    always_comb begin
        any_clamp = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            // NOTE: blocking assignments here model combinational data flow;
            // registered state below is written only with non-blocking ones.
            sum[i]     = (ACC_W+1)'(acc[i]) + (ACC_W+1)'(prod[i]);
            acc_new[i] = sum[i][ACC_W-1:0];
            if (sum[i][ACC_W] != sum[i][ACC_W-1]) begin
                any_clamp  = 1'b1;
                acc_new[i] = sum[i][ACC_W] ? ACC_MIN : ACC_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wreg       <= '0;
            next_pixel <= '0;
            v1         <= 1'b0;
            last1      <= 1'b0;
            v2         <= 1'b0;
            last2      <= 1'b0;
            count      <= '0;
            len_q      <= '0;
            sticky     <= 1'b0;
            psum       <= '0;
            sat        <= 1'b0;
            out_valid  <= 1'b0;
            // NOTE: the per-lane product and accumulator arrays are plain
            // flops, not a RAM, so they are reset lane by lane; the first
            // group of a run relies on the accumulators starting at zero.
            for (int i = 0; i < NUM_PE; i++) begin
                prod[i] <= '0;
                acc[i]  <= '0;
            end
        end else begin
            // Weights load regardless of stalls; a held S2 product keeps the
            // weight it was computed with.
            if (weight_load) begin
                wreg <= weight;
            end

            if (clear) begin
                v1        <= 1'b0;
                last1     <= 1'b0;
                v2        <= 1'b0;
                last2     <= 1'b0;
                count     <= '0;
                sticky    <= 1'b0;
                out_valid <= 1'b0;
                for (int i = 0; i < NUM_PE; i++) begin
                    acc[i] <= '0;
                end
            end else begin
                if (en) begin
                    // S1
                    next_pixel <= sel_pix;
                    v1         <= accept;
                    last1      <= accept && last_beat;
                    if (accept) begin
                        if (count == '0) begin
                            len_q <= acc_len;
                        end
                        count <= last_beat ? '0 : count + LEN_W'(1);
                    end

                    // S2
                    v2    <= v1;
                    last2 <= last1;
                    for (int i = 0; i < NUM_PE; i++) begin
                        prod[i] <= PROD_W'($signed(next_pixel[i])) *
                                   PROD_W'($signed(wreg[i]));
                    end

                    // S3: a completing group publishes its sum and restarts
                    // the accumulators from zero for the next group.
                    if (v2) begin
                        if (last2) begin
                            for (int i = 0; i < NUM_PE; i++) begin
                                psum[i] <= acc_new[i];
                                acc[i]  <= '0;
                            end
                            sat    <= sticky || any_clamp;
                            sticky <= 1'b0;
                        end else begin
                            for (int i = 0; i < NUM_PE; i++) begin
                                acc[i] <= acc_new[i];
                            end
                            sticky <= sticky || any_clamp;
                        end
                    end
                end

                // A completion in the same cycle as a consume keeps valid high
                // with the new psum.
                if (en && v2 && last2) begin
                    out_valid <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
